// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN front end: image geometry, pixel
// width and the raster streamer state encoding.
package cnn_pkg;

    localparam int IMG_W      = 28;
    localparam int PAD        = 2;
    localparam int OUT_W      = IMG_W + 2 * PAD;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = 784;
    localparam int ADDR_W     = 10;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } state_t;

endpackage

// File: rtl/image_ram.sv
// Single-image pixel store: one write port, one synchronous read port,
// write-first on a same-address collision, no reset on the storage.
module image_ram #(
    parameter int DEPTH = cnn_pkg::IMG_PIXELS,
    parameter int AW    = cnn_pkg::ADDR_W,
    parameter int DW    = cnn_pkg::PIX_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads outside the array only happen for padding beats, whose data is ignored.
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else if (raddr < DEPTH_A) begin
            rdata <= mem[raddr];
        end else begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/mnist_pixel_streamer.sv
// Streams a stored 28x28 image as a zero-padded 32x32 raster with
// valid/ready handshaking and frame start/end markers.
module mnist_pixel_streamer #(
    parameter int               IMG_W     = cnn_pkg::IMG_W,
    parameter int               PAD       = cnn_pkg::PAD,
    parameter int               PIX_W     = cnn_pkg::PIX_W,
    parameter logic [PIX_W-1:0] PAD_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [9:0]       wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             start,
    input  logic             pix_ready,
    output logic [PIX_W-1:0] pix_data,
    output logic             pix_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    import cnn_pkg::state_t;
    import cnn_pkg::IDLE;
    import cnn_pkg::PRIME;
    import cnn_pkg::STREAM;

    localparam int OUT_W      = IMG_W + 2 * PAD;
    localparam int IMG_PIXELS = IMG_W * IMG_W;
    localparam int CW         = $clog2(OUT_W);
    localparam int AW         = 10;

    localparam logic [CW-1:0] LO      = CW'(PAD);
    localparam logic [CW-1:0] HI      = CW'(PAD + IMG_W);
    localparam logic [CW-1:0] HI_LAST = CW'(PAD + IMG_W - 1);
    localparam logic [CW-1:0] LAST    = CW'(OUT_W - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] PAD_A    = AW'(PAD);
    localparam logic [AW-1:0] DEPTH_A  = AW'(IMG_PIXELS);

    state_t state, state_next;

    logic [CW-1:0]    ox, oy, ox_n, oy_n;
    logic [AW-1:0]    row_base, row_base_n;
    logic [AW-1:0]    rd_addr;
    logic [PIX_W-1:0] ram_q;
    logic             pad_q, fs_q, fe_q;
    logic             next_pad;
    logic             accept;
    logic             ram_we;

    assign accept = (state == STREAM) && pix_ready;
    assign ram_we = (state == IDLE) && wr_en && (wr_addr < DEPTH_A);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PRIME;
            PRIME:   state_next = STREAM;
            STREAM:  if (accept && (ox == LAST) && (oy == LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The coordinate that will be on the output after this edge; the RAM is
    // addressed from it so the read lands together with the coordinate.
    always_comb begin
        ox_n       = ox;
        oy_n       = oy;
        row_base_n = row_base;
        if (accept) begin
            if (ox == LAST) begin
                ox_n = '0;
                if (oy == LAST) begin
                    oy_n       = '0;
                    row_base_n = '0;
                end else begin
                    oy_n = oy + ONE;
                    if ((oy >= LO) && (oy < HI_LAST)) begin
                        row_base_n = row_base + ROW_STEP;
                    end
                end
            end else begin
                ox_n = ox + ONE;
            end
        end
    end

    assign rd_addr  = row_base_n + AW'(ox_n) - PAD_A;
    assign next_pad = !((ox_n >= LO) && (ox_n < HI) && (oy_n >= LO) && (oy_n < HI));

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE)) begin
            ox       <= '0;
            oy       <= '0;
            row_base <= '0;
            pad_q    <= 1'b1;
            fs_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            ox       <= ox_n;
            oy       <= oy_n;
            row_base <= row_base_n;
            pad_q    <= next_pad;
            fs_q     <= (ox_n == '0) && (oy_n == '0);
            fe_q     <= (ox_n == LAST) && (oy_n == LAST);
        end
    end

    image_ram #(
        .DEPTH (IMG_PIXELS),
        .AW    (AW),
        .DW    (PIX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    assign pix_valid   = (state == STREAM);
    assign busy        = (state != IDLE);
    assign pix_data    = pix_valid ? (pad_q ? PAD_VALUE : ram_q) : '0;
    assign frame_start = pix_valid && fs_q;
    assign frame_end   = pix_valid && fe_q;

endmodule
